// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer width, Gray/binary conversion and skid-buffer state encoding.
package fifo_pkg;

  // Widest pointer the conversion helpers handle; narrower pointers are zero-extended.
  localparam int unsigned MaxPtrWidth = 32;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } skid_state_e;

  // Pointers carry one extra wrap bit above the memory address bits.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [MaxPtrWidth-1:0] bin2gray(input logic [MaxPtrWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended inputs decode correctly because leading zeros stay zero.
  function automatic logic [MaxPtrWidth-1:0] gray2bin(input logic [MaxPtrWidth-1:0] gray);
    logic [MaxPtrWidth-1:0] bin;
    bin[MaxPtrWidth-1] = gray[MaxPtrWidth-1];
    for (int i = MaxPtrWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_skid_buffer.sv
// Two-entry FIFO output buffer; entry0 is always the oldest word.
module fifo_skid_buffer
  import fifo_pkg::*;
#(
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [1:0]           count_o,
  output logic [DataWidth-1:0] head_o
);

  skid_state_e          state_q, state_d;
  logic [DataWidth-1:0] entry0_q, entry0_d;
  logic [DataWidth-1:0] entry1_q, entry1_d;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  // Next state and entry updates; pops against an empty buffer are ignored.
  always_comb begin
    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    unique case (state_q)
      StEmpty: begin
        if (push_i) begin
          state_d  = StOne;
          entry0_d = push_data_i;
        end
      end
      StOne: begin
        if (push_i && pop_i) begin
          entry0_d = push_data_i;
        end else if (push_i) begin
          state_d  = StTwo;
          entry1_d = push_data_i;
        end else if (pop_i) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop_i) begin
          entry0_d = entry1_q;
          if (push_i) begin
            entry1_d = push_data_i;
          end else begin
            state_d = StOne;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    head_o = entry0_q;
    unique case (state_q)
      StOne:   count_o = 2'd1;
      StTwo:   count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

  // The issue logic upstream must never push into a full buffer without a pop.
  overflow_chk: assert property (@(posedge clk_i) disable iff (rst_i)
    !(state_q == StTwo && push_i && !pop_i));

endmodule

// File: rtl/fifo_rd_prefetch.sv
// FIFO read side: prefetches from a registered-read memory into a 2-entry valid/ready buffer.
module fifo_rd_prefetch
  import fifo_pkg::*;
#(
  parameter int unsigned AddressWidth = 4,
  parameter int unsigned DataWidth    = 64,
  localparam int unsigned PtrWidth    = ptr_width(AddressWidth)
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic [PtrWidth-1:0]     wr_ptr_gray_sync,
  output logic [PtrWidth-1:0]     rd_ptr_gray,
  output logic                    mem_rd_req,
  output logic [AddressWidth-1:0] mem_rd_addr,
  input  logic [DataWidth-1:0]    mem_rd_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DataWidth-1:0]    m_data
);

  logic [PtrWidth-1:0]    rd_bin_q, rd_bin_d;
  logic [PtrWidth-1:0]    rd_gray_q, rd_gray_d;
  logic [PtrWidth-1:0]    wr_bin;
  logic [MaxPtrWidth-1:0] wr_bin_full, rd_gray_full;
  logic                   inflight_q;
  logic                   mem_avail, pop, issue;
  logic [1:0]             count;
  logic [2:0]             occupancy;
  logic                   unused_conv_bits;

  // Pointer conversion through the shared package helpers.
  always_comb begin
    wr_bin_full  = gray2bin(MaxPtrWidth'(wr_ptr_gray_sync));
    wr_bin       = wr_bin_full[PtrWidth-1:0];
    rd_gray_full = bin2gray(MaxPtrWidth'(rd_bin_d));
    rd_gray_d    = rd_gray_full[PtrWidth-1:0];
  end

  assign unused_conv_bits = ^{wr_bin_full[MaxPtrWidth-1:PtrWidth],
                              rd_gray_full[MaxPtrWidth-1:PtrWidth]};

  // Issue a read only when the word it fetches is guaranteed a buffer slot.
  always_comb begin
    mem_avail = (rd_bin_q != wr_bin);
    pop       = m_valid && m_ready;
    // pop implies count >= 1, so this never underflows.
    occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = mem_avail && (occupancy < 3'd2);
    rd_bin_d  = issue ? rd_bin_q + PtrWidth'(1) : rd_bin_q;
  end

  // Read pointer, exported Gray pointer and in-flight flag.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= rd_gray_d;
      inflight_q <= issue;
    end
  end

  // Memory request and consumer-facing outputs.
  always_comb begin
    mem_rd_req  = issue && !rd_rst;
    mem_rd_addr = rd_bin_q[AddressWidth-1:0];
    rd_ptr_gray = rd_gray_q;
    m_valid     = (count != 2'd0);
  end

  // Memory data returns the cycle after the request and lands in the buffer.
  fifo_skid_buffer #(
    .DataWidth (DataWidth)
  ) u_skid (
    .clk_i       (rd_clk),
    .rst_i       (rd_rst),
    .push_i      (inflight_q),
    .push_data_i (mem_rd_data),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Self-checking bench for fifo_rd_prefetch with a registered-read memory model and scoreboard.
module tb_fifo_rd_prefetch;

  localparam int unsigned Aw = 2;
  localparam int unsigned Dw = 8;
  localparam int unsigned Depth = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic [Aw:0]   wr_ptr_gray_sync = '0;
  logic [Aw:0]   rd_ptr_gray;
  logic          mem_rd_req;
  logic [Aw-1:0] mem_rd_addr;
  logic [Dw-1:0] mem_rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [Dw-1:0] m_data;

  logic [Dw-1:0] mem [Depth];
  logic [Dw-1:0] exp_q [$];
  int            wr_bin = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  fifo_rd_prefetch #(
    .AddressWidth (Aw),
    .DataWidth    (Dw)
  ) dut (
    .rd_clk           (rd_clk),
    .rd_rst           (rd_rst),
    .wr_ptr_gray_sync (wr_ptr_gray_sync),
    .rd_ptr_gray      (rd_ptr_gray),
    .mem_rd_req       (mem_rd_req),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_data      (mem_rd_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data)
  );

  always #5 rd_clk = ~rd_clk;

  // Registered-read memory: data appears the cycle after the request.
  always @(posedge rd_clk) begin
    if (mem_rd_req) mem_rd_data <= mem[mem_rd_addr];
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [Aw:0] to_gray(input int b);
    logic [Aw:0] v;
    v = b[Aw:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(input logic [Aw:0] g);
    logic [Aw:0] v;
    v[2] = g[2];
    v[1] = v[2] ^ g[1];
    v[0] = v[1] ^ g[0];
    return int'(v);
  endfunction

  task automatic set_wr(input int b);
    wr_bin = b & 7;
    wr_ptr_gray_sync = to_gray(wr_bin);
  endtask

  // Reset with checks while asserted; memory reloaded with 0xA0+i.
  task automatic do_reset();
    rd_rst = 1'b1;
    m_ready = 1'b0;
    set_wr(0);
    exp_q.delete();
    for (int i = 0; i < Depth; i++) mem[i] = 8'hA0 + 8'(i);
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_req", mem_rd_req, 0);
    check("rst_gray", rd_ptr_gray, 0);
    check("rst_data", m_data, 0);
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  // Writer + consumer loop against the scoreboard queue.
  task automatic run_stream(input int n_words, input int ready_pct, input int max_cycles,
                            output int first_valid, output int first_pop, output int last_pop,
                            output int seen_wrap);
    int          written, popped, cyc, rd_b;
    logic        prev_valid, prev_pop, pop;
    logic [Dw-1:0] prev_data, d, exp_d;
    logic [Aw:0] prev_gray;
    written = 0; popped = 0; cyc = 0;
    prev_valid = 0; prev_pop = 0; prev_data = '0; prev_gray = rd_ptr_gray;
    first_valid = -1; first_pop = -1; last_pop = -1; seen_wrap = 0;
    while (popped < n_words && cyc < max_cycles) begin
      @(posedge rd_clk);
      #1;
      rd_b = from_gray(rd_ptr_gray);
      if (written < n_words && ((wr_bin - rd_b) & 7) < Depth) begin
        d = 8'($urandom);
        mem[wr_bin % Depth] = d;
        exp_q.push_back(d);
        set_wr(wr_bin + 1);
        written++;
      end
      m_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (prev_gray == 3'd4 && rd_ptr_gray == 3'd0) seen_wrap = 1;
      prev_gray = rd_ptr_gray;
      if (prev_valid && !prev_pop) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      pop = m_valid && m_ready;
      if (pop) begin
        check("pop_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          check("order", m_data, exp_d);
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        popped++;
      end
      prev_valid = m_valid;
      prev_pop = pop;
      prev_data = m_data;
      cyc++;
    end
    check("stream_count", popped, n_words);
    // Drained: nothing left and no duplicate word appears.
    m_ready = 1'b1;
    repeat (4) @(posedge rd_clk);
    #1;
    check("drain_valid", m_valid, 0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    int n_req, fv, fp, lp, wrap;

    // Reset and idle with an empty memory.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge rd_clk);
      #1;
      check("idle_valid", m_valid, 0);
      check("idle_req", mem_rd_req, 0);
      check("idle_gray", rd_ptr_gray, 0);
    end

    // Single word: issue at N, pointer at N+1, data at N+2.
    do_reset();
    @(posedge rd_clk);
    #1;
    set_wr(1);
    #1;
    check("one_req", mem_rd_req, 1);
    check("one_addr", mem_rd_addr, 0);
    check("one_valid_n", m_valid, 0);
    @(posedge rd_clk);
    #2;
    check("one_gray_n1", rd_ptr_gray, 1);
    check("one_req_n1", mem_rd_req, 0);
    check("one_valid_n1", m_valid, 0);
    @(posedge rd_clk);
    #2;
    check("one_valid_n2", m_valid, 1);
    check("one_data_n2", m_data, 8'hA0);
    for (int i = 0; i < 3; i++) begin
      @(posedge rd_clk);
      #2;
      check("one_hold_valid", m_valid, 1);
      check("one_hold_data", m_data, 8'hA0);
    end

    // Four words available, consumer stalled: two reads then stall; then drain in order.
    do_reset();
    @(posedge rd_clk);
    #1;
    set_wr(4);
    n_req = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mem_rd_req) n_req++;
      @(posedge rd_clk);
      #1;
    end
    #1;
    check("stall_reads", n_req, 2);
    check("stall_gray", rd_ptr_gray, 3);
    check("stall_valid", m_valid, 1);
    check("stall_data", m_data, 8'hA0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("burst_valid", m_valid, 1);
      check("burst_data", m_data, 8'hA0 + 8'(i));
      @(posedge rd_clk);
      #2;
    end
    check("burst_end_valid", m_valid, 0);

    // Continuous stream with wrap and full throughput.
    do_reset();
    run_stream(20, 100, 200, fv, fp, lp, wrap);
    check("stream_latency", fv, 2);
    check("stream_first_pop", fp, 2);
    check("stream_b2b", lp - fp + 1, 20);
    check("stream_wrap", wrap, 1);

    // Random back-pressure.
    do_reset();
    run_stream(100, 50, 3000, fv, fp, lp, wrap);
    check("rand_wrap", wrap, 1);

    // Asynchronous reset while the buffer holds two words.
    do_reset();
    @(posedge rd_clk);
    #1;
    set_wr(4);
    repeat (5) @(posedge rd_clk);
    #2;
    check("pre_rst_valid", m_valid, 1);
    check("pre_rst_gray", rd_ptr_gray, 3);
    rd_rst = 1'b1;
    #1;
    check("async_valid", m_valid, 0);
    check("async_req", mem_rd_req, 0);
    check("async_gray", rd_ptr_gray, 0);
    check("async_data", m_data, 0);
    set_wr(0);
    @(negedge rd_clk);
    rd_rst = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge rd_clk);
    #1;
    check("post_rst_valid", m_valid, 0);
    check("post_rst_gray", rd_ptr_gray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_prefetch.md
FIFO_RD_PREFETCH -- requirements
Module: fifo_rd_prefetch

Interface
REQ-001 SHALL have parameter AddressWidth, default 4: memory address bits; depth = 2^AddressWidth.
REQ-002 SHALL have parameter DataWidth, default 64: word width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: rd_clk  in  1  read-domain clock, all state on rising edge.
REQ-004 rd_rst  in  1  asynchronous active-high reset.
REQ-005 wr_ptr_gray_sync  in  AddressWidth+1  write pointer, Gray-coded, already synchronized into rd_clk.
REQ-006 rd_ptr_gray  out  AddressWidth+1  registered Gray read pointer, exported to the write side.
REQ-007 mem_rd_req  out  1  read request to a registered-read (non-FWFT) memory.
REQ-008 mem_rd_addr  out  AddressWidth  read address, equal to the low AddressWidth bits of the binary read pointer.
REQ-009 mem_rd_data  in  DataWidth  memory data, valid the cycle after mem_rd_req.
REQ-010 m_valid  out  1; m_ready  in  1; m_data  out  DataWidth: consumer valid/ready stream.

Function
REQ-011 SHALL keep a binary read pointer rd_bin (AddressWidth+1 bits) wrapping modulo 2^(AddressWidth+1).
REQ-012 SHALL decode wr_bin from wr_ptr_gray_sync combinationally; mem_avail = (rd_bin != wr_bin), compared full-width.
REQ-013 SHALL hold a 2-entry output buffer with states EMPTY, ONE, TWO, plus a 1-bit in-flight flag.
REQ-014 pop = m_valid && m_ready; issue = mem_avail && (count + inflight - pop) < 2.
REQ-015 mem_rd_req SHALL equal issue, combinational, forced 0 while rd_rst is high.
REQ-016 On issue, rd_bin SHALL increment and rd_ptr_gray SHALL update to the Gray code of the new rd_bin at the same edge.
REQ-017 inflight SHALL be set the cycle after issue; mem_rd_data SHALL be written into the buffer at the end of that cycle.
REQ-018 Latency SHALL be 2 cycles: issue in cycle N gives m_valid=1 in N+2 when the buffer is empty.
REQ-019 m_valid SHALL be (count != 0); m_data SHALL be the oldest entry; order SHALL be strict FIFO.
REQ-020 Simultaneous push and pop SHALL keep count unchanged and preserve order (ONE to ONE, TWO to TWO).
REQ-021 Transitions SHALL be:
- EMPTY to ONE on push.
- ONE to TWO on push without pop.
- ONE to EMPTY on pop without push.
- TWO to ONE on pop without push.
REQ-022 Push while TWO without pop SHALL be impossible by REQ-014; an assertion SHALL flag it.
REQ-023 Once m_valid=1, m_valid and m_data SHALL stay stable until pop.
REQ-024 With m_ready held high and mem_avail held high, throughput SHALL be 1 word per cycle.
REQ-025 When mem_avail=0, SHALL issue nothing; buffered words SHALL remain deliverable.

Reset
REQ-026 rd_rst SHALL act immediately, without a clock edge, and SHALL produce:
- rd_bin=0, rd_ptr_gray=0, inflight=0, state EMPTY.
- m_valid=0, m_data=0, mem_rd_req=0.
REQ-027 Reset mid-operation SHALL discard buffered and in-flight data; the write side is reset coherently by the system.

Structure
REQ-028 Gray/binary conversion functions SHALL live in a shared package fifo_pkg, for reuse by the write-pointer logic.
REQ-029 The pointer-width constant (AddressWidth+1) SHALL also live in fifo_pkg.
REQ-030 The 2-entry buffer SHALL be a sub-module fifo_skid_buffer (push/pop/count/head interface).

Verification (AddressWidth=2, DataWidth=8, memory model preloaded mem[i]=0xA0+i)
REQ-031 Reset, wr_ptr_gray_sync=0, 10 cycles -> m_valid=0, mem_rd_req=0, rd_ptr_gray=0 throughout.
REQ-032 wr_ptr_gray_sync 0 to 1, m_ready=0 -> mem_rd_req=1 with addr 0 at N; rd_ptr_gray=1 at N+1; m_valid=1 with m_data=0xA0 at N+2, held stable.
REQ-033 wr_ptr_gray_sync=6 (bin 4), m_ready=0 -> exactly 2 reads issued, then stall with rd_ptr_gray=3. Then m_ready=1 -> 0xA0..0xA3 in order, back-to-back.
REQ-034 Continuous stream of 20 words, m_ready=1 -> pointer wraps bin 7 to 0 (Gray 4 to 0); 1 word/cycle after 2-cycle latency; no loss, no duplication.
REQ-035 100 words with 50% random m_ready -> scoreboard order match; m_data stable during every stall.
REQ-036 rd_rst asserted mid-stream with state TWO -> m_valid=0, mem_rd_req=0, rd_ptr_gray=0 before the next rd_clk edge.
